seg_scan_decoder: RTL and testbench

//  Inverse of the 7-seg pattern encoder. Snoops the multiplexed display bus: active-low anodes

---
 rtl/seg_pkg.sv | 15 +
 rtl/seg_pattern_lookup.sv | 24 ++
 rtl/seg_scan_decoder.sv | 127 ++++++++++++
 tb/tb_seg_scan_decoder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions for the pattern encoder and the scan decoder.
//   SEG_PAT    : active-low segment pattern for each hex digit, {dp=1, g..a}
//   SEG_DP_BIT : bit position of the decimal point inside an 8-bit pattern
//   SEG_BLANK  : all segments dark
package seg_pkg;

   localparam int         SEG_DP_BIT = 7;
   localparam logic [7:0] SEG_BLANK  = 8'hFF;

   localparam logic [7:0] SEG_PAT [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

endpackage

// File: rtl/seg_pattern_lookup.sv
// Combinational reverse lookup of a seven-segment pattern.
//   segs   in  7  active-low segments g..a (decimal point excluded)
//   hit    out 1  segs matches one of the sixteen hex glyphs
//   nibble out 4  hex value of the matching glyph, 0 when no match
module seg_pattern_lookup
   import seg_pkg::*;
(
   input  logic [6:0] segs,
   output logic       hit,
   output logic [3:0] nibble
);

   always_comb begin
      hit    = 1'b0;
      nibble = 4'h0;
      for (int k = 0; k < 16; k++) begin
         if (segs == SEG_PAT[k][6:0]) begin
            hit    = 1'b1;
            nibble = 4'(k);
         end
      end
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Readback monitor for a multiplexed seven-segment display bus.
// Watches the active-low anode and segment lines, accepts a digit once the
// same legal (anode, pattern) pair has been held long enough, decodes it and
// publishes a whole frame when every digit has been captured.
//   clk         in  1       rising-edge clock
//   rst         in  1       synchronous active-high reset
//   an          in  NDIG    active-low digit enables
//   patt        in  8       active-low segments, [7]=dp, [6:0]=g..a
//   value       out 4*NDIG  last complete frame, digit i at [4*i+3:4*i]
//   dp_out      out NDIG    last complete frame decimal points, 1 = lit
//   digit_seen  out NDIG    digits accepted so far in the current frame
//   frame_valid out 1       pulse: value/dp_out were just updated
//   bad_pattern out 1       pulse: an accepted sample was not a hex glyph
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int NDIG          = 8,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 3
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [NDIG-1:0]   an,
   input  logic [7:0]        patt,
   output logic [4*NDIG-1:0] value,
   output logic [NDIG-1:0]   dp_out,
   output logic [NDIG-1:0]   digit_seen,
   output logic              frame_valid,
   output logic              bad_pattern
);

   localparam int              IDX_W   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STABLE_CYCLES);

   // Registered bus sample and the sample from the cycle before it.
   logic [NDIG-1:0]   an_q, an_p;
   logic [7:0]        patt_q, patt_p;
   logic [CNT_W-1:0]  run_cnt, run_next;
   logic [4*NDIG-1:0] work_val, val_next;
   logic [NDIG-1:0]   work_dp, dp_next, seen_next;

   logic              legal, same, accept, good, frame_done;
   logic [IDX_W-1:0]  idx;
   int                zeros;
   logic              hit;
   logic [3:0]        nib;

   seg_pattern_lookup u_lookup (
      .segs   (patt_q[6:0]),
      .hit    (hit),
      .nibble (nib)
   );

   // Exactly one enabled digit makes a legal sample; idx is its position.
   always_comb begin
      zeros = 0;
      idx   = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (!an_q[i]) begin
            zeros = zeros + 1;
            idx   = IDX_W'(i);
         end
      end
      legal = (zeros == 1);
   end

   assign same = (an_q == an_p) && (patt_q == patt_p);

   always_comb begin
      if (!legal)                run_next = '0;
      else if (!same)            run_next = CNT_W'(1);
      else if (run_cnt == RUN_MAX) run_next = RUN_MAX;
      else                       run_next = run_cnt + CNT_W'(1);
   end

   // Accept only on the transition into the saturated count; a held pair
   // sitting at saturation does not fire again.
   assign accept = legal && (run_next == RUN_MAX) && !(same && (run_cnt == RUN_MAX));
   assign good   = accept && hit;

   always_comb begin
      val_next  = work_val;
      dp_next   = work_dp;
      seen_next = digit_seen;
      if (good) begin
         val_next[{idx, 2'b00} +: 4] = nib;
         dp_next[idx]                = ~patt_q[SEG_DP_BIT];
         seen_next[idx]              = 1'b1;
      end
   end

   assign frame_done = good && (&seen_next);

   always_ff @(posedge clk) begin
      if (rst) begin
         an_q        <= '1;
         patt_q      <= SEG_BLANK;
         an_p        <= '1;
         patt_p      <= SEG_BLANK;
         run_cnt     <= '0;
         work_val    <= '0;
         work_dp     <= '0;
         digit_seen  <= '0;
         value       <= '0;
         dp_out      <= '0;
         frame_valid <= 1'b0;
         bad_pattern <= 1'b0;
      end else begin
         an_q        <= an;
         patt_q      <= patt;
         an_p        <= an_q;
         patt_p      <= patt_q;
         run_cnt     <= run_next;
         work_val    <= val_next;
         work_dp     <= dp_next;
         digit_seen  <= frame_done ? '0 : seen_next;
         frame_valid <= frame_done;
         bad_pattern <= accept && !hit;
         if (frame_done) begin
            value  <= val_next;
            dp_out <= dp_next;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder (NDIG=8, STABLE_CYCLES=4): directed scenarios
// followed by randomized scanning, every cycle compared against a reference
// model that counts run lengths of identical legal samples.
module tb_seg_scan_decoder;

   localparam int NDIG = 8;
   localparam int S    = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  an = 8'hFF;
   logic [7:0]  patt = 8'hFF;
   logic [31:0] value;
   logic [7:0]  dp_out, digit_seen;
   logic        frame_valid, bad_pattern;

   int errors = 0;
   int checks = 0;
   int fv_cnt = 0;
   int bad_cnt = 0;

   seg_scan_decoder #(.NDIG(NDIG), .STABLE_CYCLES(S), .CNT_W(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .an          (an),
      .patt        (patt),
      .value       (value),
      .dp_out      (dp_out),
      .digit_seen  (digit_seen),
      .frame_valid (frame_valid),
      .bad_pattern (bad_pattern)
   );

   always #5 clk = ~clk;

   // Glyph table, active-low {dp=1, g..a}.
   logic [7:0] tbl [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   // Reference model state.
   logic [7:0]  m_an_q, m_patt_q, m_an_p, m_patt_p;
   int          run;
   logic [3:0]  wv [8];
   logic [7:0]  wd;
   logic [31:0] e_value;
   logic [7:0]  e_dp, e_seen;
   logic        e_fv, e_bad;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock of the model, given what was on the bus before the edge.
   task automatic model(input logic r, input logic [7:0] a, input logic [7:0] p);
      int pos;
      int nv;
      if (r) begin
         m_an_q = 8'hFF; m_patt_q = 8'hFF; m_an_p = 8'hFF; m_patt_p = 8'hFF;
         run = 0;
         for (int i = 0; i < 8; i++) wv[i] = 4'h0;
         wd = '0; e_value = '0; e_dp = '0; e_seen = '0; e_fv = 0; e_bad = 0;
         return;
      end
      e_fv = 0;
      e_bad = 0;
      if ($countones(~m_an_q) != 1) run = 0;
      else if (m_an_q == m_an_p && m_patt_q == m_patt_p) run = run + 1;
      else run = 1;
      if (run == S) begin
         pos = 0;
         for (int i = 0; i < 8; i++) if (!m_an_q[i]) pos = i;
         nv = -1;
         for (int k = 0; k < 16; k++) if (tbl[k][6:0] == m_patt_q[6:0]) nv = k;
         if (nv < 0) e_bad = 1;
         else begin
            wv[pos]     = 4'(nv);
            wd[pos]     = ~m_patt_q[7];
            e_seen[pos] = 1'b1;
            if (e_seen == 8'hFF) begin
               for (int i = 0; i < 8; i++) e_value[4*i +: 4] = wv[i];
               e_dp   = wd;
               e_fv   = 1;
               e_seen = '0;
            end
         end
      end
      m_an_p = m_an_q; m_patt_p = m_patt_q;
      m_an_q = a;      m_patt_q = p;
   endtask

   task automatic step(input logic r, input logic [7:0] a, input logic [7:0] p);
      @(negedge clk);
      rst = r; an = a; patt = p;
      @(posedge clk);
      model(r, a, p);
      #1;
      fv_cnt  += int'(frame_valid);
      bad_cnt += int'(bad_pattern);
      chk("value", value, e_value);
      chk("dp_out", {24'h0, dp_out}, {24'h0, e_dp});
      chk("digit_seen", {24'h0, digit_seen}, {24'h0, e_seen});
      chk("frame_valid", {31'h0, frame_valid}, {31'h0, e_fv});
      chk("bad_pattern", {31'h0, bad_pattern}, {31'h0, e_bad});
   endtask

   task automatic hold(input logic [7:0] a, input logic [7:0] p, input int n);
      for (int i = 0; i < n; i++) step(1'b0, a, p);
   endtask

   function automatic logic [7:0] an_of(input int d);
      logic [7:0] v;
      v = 8'hFF;
      v[d] = 1'b0;
      return v;
   endfunction

   initial begin
      logic [7:0] a, p;
      int         n, sel;
      logic [7:0] scan_p [8];

      // Reset.
      step(1'b1, 8'hFF, 8'hFF);
      step(1'b1, 8'hFF, 8'hFF);
      chk("reset_value", value, 32'h0);
      chk("reset_seen", {24'h0, digit_seen}, 32'h0);

      // 1: single digit held; accepted once.
      fv_cnt = 0;
      hold(8'hFE, 8'hC0, 5);
      chk("t1_seen_after5", {24'h0, digit_seen}, 32'h01);
      hold(8'hFE, 8'hC0, 15);
      chk("t1_seen_held", {24'h0, digit_seen}, 32'h01);
      chk("t1_no_frame", fv_cnt, 0);

      // 2: full scan.
      scan_p = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};
      fv_cnt = 0;
      for (int d = 0; d < 8; d++) hold(an_of(d), scan_p[d], 6);
      chk("t2_frames", fv_cnt, 1);
      chk("t2_value", value, 32'h87654321);
      chk("t2_dp", {24'h0, dp_out}, 32'h0);
      chk("t2_seen", {24'h0, digit_seen}, 32'h0);

      // 3: flicker on digit 3, then a stable 1 with dp lit.
      for (int i = 0; i < 6; i++) hold(8'hF7, (i % 2 == 0) ? 8'hC0 : 8'hF9, 2);
      chk("t3_no_accept", {24'h0, digit_seen}, 32'h0);
      hold(8'hF7, 8'h79, 6);
      chk("t3_seen3", {24'h0, digit_seen}, 32'h08);
      fv_cnt = 0;
      for (int d = 0; d < 8; d++) if (d != 3) hold(an_of(d), 8'hC0, 6);
      chk("t3_frames", fv_cnt, 1);
      chk("t3_value", value, 32'h00001000);
      chk("t3_dp", {24'h0, dp_out}, 32'h08);

      // 4: illegal anodes, then an undecodable pattern.
      bad_cnt = 0;
      hold(8'hFC, 8'hC0, 10);
      hold(8'hFF, 8'hC0, 10);
      chk("t4_illegal_seen", {24'h0, digit_seen}, 32'h0);
      chk("t4_illegal_bad", bad_cnt, 0);
      hold(8'hFB, 8'hFF, 6);
      chk("t4_bad_once", bad_cnt, 1);
      chk("t4_seen2", {24'h0, digit_seen}, 32'h0);

      // 5: last write wins on digit 5, then mid-frame reset.
      hold(8'hDF, 8'h92, 6);
      hold(8'hDF, 8'h8E, 6);
      for (int d = 0; d < 8; d++) if (d != 5) hold(an_of(d), 8'hC0, 6);
      chk("t5_nibble5", {28'h0, value[23:20]}, 32'hF);
      chk("t5_value", value, 32'h00F00000);
      hold(8'hFE, 8'hA4, 6);
      hold(8'hFD, 8'hB0, 6);
      step(1'b1, 8'hFB, 8'h99);
      step(1'b1, 8'hFB, 8'h99);
      chk("t5_rst_seen", {24'h0, digit_seen}, 32'h0);
      chk("t5_rst_value", value, 32'h0);

      // Randomized scanning with glitches, illegal anodes and junk patterns.
      for (int s = 0; s < 250; s++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0)      a = 8'hFF;
         else if (sel == 1) a = 8'($urandom) & ~(an_of($urandom_range(0, 7)) ^ 8'hFF) & 8'hFC;
         else               a = an_of($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) p = 8'($urandom);
         else begin
            p = tbl[$urandom_range(0, 15)];
            p[7] = 1'($urandom_range(0, 1));
         end
         n = $urandom_range(1, 7);
         hold(a, p, n);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
